frame_sequencer: RTL and testbench

Readout scheduler for the spectrogram extractor. It turns overflow events and periodic RTC frame requests into a serialised readout of all 16 counter words: word 0 is the RTC time stamp and words 1–15 are the channel counters. It drives the mux select and the PISO load/shift strobe, freezes the counters while a frame is in flight, and clears them once the frame completes. Requests that arrive while a frame is in flight are queued one deep, and requests beyond that are counted as drops.

---
 rtl/frame_seq_pkg.sv | 22 ++
 rtl/frame_sequencer_req_queue.sv | 73 +++++++
 rtl/frame_sequencer.sv | 163 ++++++++++++++++
 tb/tb_frame_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_seq_pkg.sv
// Shared types and constants for the frame sequencer.
// FRAME_SEQ_PARITY_EN adds a parity slot after every word.
package frame_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        PAR,
        CLEAR
    } state_e;

    localparam int NUM_WORDS_DEF = 16;
    localparam int WORD_W_DEF    = 12;

`ifdef FRAME_SEQ_PARITY_EN
    localparam int CYC_PER_WORD = WORD_W_DEF + 2;
`else
    localparam int CYC_PER_WORD = WORD_W_DEF + 1;
`endif

endpackage

// File: rtl/frame_sequencer_req_queue.sv
// Request front end: ovf edge detect, request merge, one-deep pending slot
// with latched cause, and a saturating drop counter.
module req_queue
    import frame_seq_pkg::*;
#(
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ovf_i,
    input  logic              rtc_tick_i,
    input  logic              idle_i,
    input  logic              clear_i,
    output logic              start_o,
    output logic              start_trig_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    logic              ovf_q;
    logic              pend_q, pend_d;
    logic              ptrig_q, ptrig_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              ovf_rise;
    logic              req;

    assign ovf_rise = ovf_i & ~ovf_q;
    assign req      = rtc_tick_i | ovf_rise;

    always_comb begin
        pend_d       = pend_q;
        ptrig_d      = ptrig_q;
        drop_d       = drop_q;
        start_o      = 1'b0;
        start_trig_o = ovf_rise;
        if (idle_i) begin
            start_o = req;
        end else begin
            if (req) begin
                if (pend_q) begin
                    if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
                end else if (!clear_i) begin
                    pend_d  = 1'b1;
                    ptrig_d = ovf_rise;
                end
            end
            // CLEAR hands the queued (or just-arrived) request straight to the next frame.
            if (clear_i) begin
                start_o      = pend_q | req;
                start_trig_o = pend_q ? ptrig_q : ovf_rise;
                pend_d       = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_q   <= 1'b0;
            pend_q  <= 1'b0;
            ptrig_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            ovf_q   <= ovf_i;
            pend_q  <= pend_d;
            ptrig_q <= ptrig_d;
            drop_q  <= drop_d;
        end
    end

    assign drop_cnt_o = drop_q;

endmodule

// File: rtl/frame_sequencer.sv
// Readout scheduler: serialises NUM_WORDS counter words through mux + PISO.
// Build with FRAME_SEQ_PARITY_EN to append an even-parity cycle per word.
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int  NUM_WORDS = NUM_WORDS_DEF,
    parameter int  WORD_W    = WORD_W_DEF,
    parameter int  DROP_W    = 8,
    localparam int SEL_W     = $clog2(NUM_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ovf,
    input  logic              rtc_tick,
    input  logic [WORD_W-1:0] word_in,
    output logic [SEL_W-1:0]  sel,
    output logic              sl,
    output logic              par_bit,
    output logic              par_valid,
    output logic              freeze,
    output logic              cnt_clr,
    output logic              busy,
    output logic              frame_start,
    output logic              frame_done,
    output logic              trig_src,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int               BIT_W  = $clog2(WORD_W);
    localparam logic [SEL_W-1:0] LAST_K = SEL_W'(NUM_WORDS - 1);
    localparam logic [BIT_W-1:0] LAST_B = BIT_W'(WORD_W - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] k_q, k_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             trig_q, trig_d;
    logic             sl_q, busy_q, cnt_clr_q, frame_start_q;
    logic [SEL_W-1:0] sel_q;
    logic             start, start_trig;
    state_e           adv_state;
    logic [SEL_W-1:0] adv_k;

    req_queue #(.DROP_W(DROP_W)) u_req_queue (
        .clk          (clk),
        .reset        (reset),
        .ovf_i        (ovf),
        .rtc_tick_i   (rtc_tick),
        .idle_i       (state_q == IDLE),
        .clear_i      (state_q == CLEAR),
        .start_o      (start),
        .start_trig_o (start_trig),
        .drop_cnt_o   (drop_cnt)
    );

    // Step taken once a word's slot (shift, plus parity if present) is over.
    assign adv_state = (k_q == LAST_K) ? CLEAR : LOAD;
    assign adv_k     = (k_q == LAST_K) ? k_q : k_q + SEL_W'(1);

    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        bit_d   = bit_q;
        trig_d  = trig_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    k_d     = '0;
                    trig_d  = start_trig;
                end
            end
            LOAD: begin
                state_d = SHIFT;
                bit_d   = '0;
            end
            SHIFT: begin
                if (bit_q == LAST_B) begin
`ifdef FRAME_SEQ_PARITY_EN
                    state_d = PAR;
`else
                    state_d = adv_state;
                    k_d     = adv_k;
`endif
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end
            PAR: begin
                state_d = adv_state;
                k_d     = adv_k;
            end
            CLEAR: begin
                if (start) begin
                    state_d = LOAD;
                    k_d     = '0;
                    trig_d  = start_trig;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            k_q           <= '0;
            bit_q         <= '0;
            trig_q        <= 1'b0;
            sl_q          <= 1'b0;
            sel_q         <= '0;
            busy_q        <= 1'b0;
            cnt_clr_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            bit_q         <= bit_d;
            trig_q        <= trig_d;
            sl_q          <= (state_d == LOAD);
            sel_q         <= (state_d == IDLE) ? '0 : k_d;
            busy_q        <= (state_d != IDLE);
            cnt_clr_q     <= (state_d == CLEAR);
            frame_start_q <= (state_d == LOAD) && (k_d == '0);
        end
    end

`ifdef FRAME_SEQ_PARITY_EN
    logic par_q, par_valid_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            par_q       <= 1'b0;
            par_valid_q <= 1'b0;
        end else begin
            if (state_q == LOAD) par_q <= ^word_in;
            par_valid_q <= (state_d == PAR);
        end
    end

    assign par_bit   = par_q;
    assign par_valid = par_valid_q;
`else
    logic unused_word_in;
    assign unused_word_in = ^word_in;
    assign par_bit        = 1'b0;
    assign par_valid      = 1'b0;
`endif

    assign sl          = sl_q;
    assign sel         = sel_q;
    assign freeze      = busy_q;
    assign busy        = busy_q;
    assign cnt_clr     = cnt_clr_q;
    assign frame_done  = cnt_clr_q;
    assign frame_start = frame_start_q;
    assign trig_src    = trig_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: frame-offset reference model plus
// directed scenarios and random requests. Honours FRAME_SEQ_PARITY_EN.
module tb_frame_sequencer;

    localparam int NW = 16;
    localparam int W  = 12;
`ifdef FRAME_SEQ_PARITY_EN
    localparam int C           = W + 2;
    localparam bit PAR_EN      = 1'b1;
    localparam int EXP_CLR_OFF = 224;
`else
    localparam int C           = W + 1;
    localparam bit PAR_EN      = 1'b0;
    localparam int EXP_CLR_OFF = 208;
`endif
    localparam int FL = C * NW;

    logic        clk = 1'b0;
    logic        reset;
    logic        ovf;
    logic        rtc_tick;
    logic [11:0] word_in;
    logic [3:0]  sel;
    logic        sl, par_bit, par_valid, freeze, cnt_clr, busy;
    logic        frame_start, frame_done, trig_src;
    logic [7:0]  drop_cnt;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    frame_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .ovf         (ovf),
        .rtc_tick    (rtc_tick),
        .word_in     (word_in),
        .sel         (sel),
        .sl          (sl),
        .par_bit     (par_bit),
        .par_valid   (par_valid),
        .freeze      (freeze),
        .cnt_clr     (cnt_clr),
        .busy        (busy),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .trig_src    (trig_src),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: a frame is just an offset from its word-0 LOAD.
    bit m_busy, m_pend, m_ptrig, m_trig, m_ovf_prev, m_par;
    int m_off, m_drop;

    always @(posedge clk) begin
        bit rise, req;
        if (!reset) begin
            m_busy = 0; m_pend = 0; m_ptrig = 0; m_trig = 0;
            m_ovf_prev = 0; m_par = 0; m_off = 0; m_drop = 0;
        end else begin
            rise = ovf && !m_ovf_prev;
            req  = rtc_tick || rise;
            m_ovf_prev = ovf;
            if (m_busy && m_off < FL && (m_off % C) == 0) m_par = ^word_in;
            if (!m_busy) begin
                if (req) begin m_busy = 1; m_off = 0; m_trig = rise; end
            end else if (m_off == FL) begin
                if (req && m_pend && m_drop < 255) m_drop++;
                if (m_pend) begin m_off = 0; m_trig = m_ptrig; m_pend = 0; end
                else if (req) begin m_off = 0; m_trig = rise; end
                else m_busy = 0;
            end else begin
                if (req) begin
                    if (m_pend) begin
                        if (m_drop < 255) m_drop++;
                    end else begin
                        m_pend = 1; m_ptrig = rise;
                    end
                end
                m_off++;
            end
        end
    end

    always @(negedge clk) begin
        bit e_load, e_par, e_clr;
        if (chk_en) begin
            e_load = m_busy && m_off < FL && (m_off % C) == 0;
            e_par  = PAR_EN && m_busy && m_off < FL && (m_off % C) == C - 1;
            e_clr  = m_busy && m_off == FL;
            check("sl", 32'(sl), 32'(e_load));
            check("busy", 32'(busy), 32'(m_busy));
            check("freeze", 32'(freeze), 32'(m_busy));
            check("cnt_clr", 32'(cnt_clr), 32'(e_clr));
            check("frame_done", 32'(frame_done), 32'(e_clr));
            check("frame_start", 32'(frame_start), 32'(e_load && m_off == 0));
            check("par_valid", 32'(par_valid), 32'(e_par));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            if (!m_busy) check("sel_idle", 32'(sel), 32'd0);
            else if (!e_clr) check("sel", 32'(sel), 32'(m_off / C));
            if (m_busy) check("trig_src", 32'(trig_src), 32'(m_trig));
            if (e_par) check("par_bit", 32'(par_bit), 32'(m_par));
            else if (!PAR_EN) check("par_bit_tied", 32'(par_bit), 32'd0);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        rtc_tick = 1'b1;
        @(negedge clk);
        rtc_tick = 1'b0;
    endtask

    // Cycles until cnt_clr, bounded; a timeout returns the bound.
    task automatic cycles_to_clr(input int bound, output int n);
        n = 0;
        while (cnt_clr !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        bit saw;
        reset = 1'b0; ovf = 1'b0; rtc_tick = 1'b0; word_in = '0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sl", 32'(sl), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        reset = 1'b1;

        // Single rtc-triggered frame.
        wait_cyc(7);
        pulse();
        check("t1_sl", 32'(sl), 32'd1);
        check("t1_sel", 32'(sel), 32'd0);
        check("t1_start", 32'(frame_start), 32'd1);
        check("t1_trig", 32'(trig_src), 32'd0);
        wait_cyc(15 * C);
        check("t1_sl15", 32'(sl), 32'd1);
        check("t1_sel15", 32'(sel), 32'd15);
        cycles_to_clr(400, n);
        check("t1_last_word_len", 32'(n), 32'(PAR_EN ? 14 : 13));
        check("t1_clear_offset", 32'(15 * C + n), 32'(EXP_CLR_OFF));
        @(negedge clk);
        check("t1_idle", 32'(busy), 32'd0);

        // ovf and rtc together: one frame, held ovf never retriggers.
        wait_cyc(3);
        ovf = 1'b1; rtc_tick = 1'b1;
        @(negedge clk);
        rtc_tick = 1'b0;
        check("t2_start", 32'(frame_start), 32'd1);
        check("t2_trig", 32'(trig_src), 32'd1);
        wait_cyc(FL);
        check("t2_clr", 32'(cnt_clr), 32'd1);
        saw = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy) saw = 1'b1;
        end
        check("t2_no_retrigger", 32'(saw), 32'd0);
        check("t2_drop", 32'(drop_cnt), 32'd0);
        ovf = 1'b0;
        wait_cyc(2);

        // Pending request and one drop: back-to-back frames.
        pulse();
        wait_cyc(5 * C + 3);
        pulse();
        wait_cyc(4 * C - 1);
        pulse();
        wait_cyc(7 * C - 4);
        check("t3_clr", 32'(cnt_clr), 32'd1);
        @(negedge clk);
        check("t3_b2b_start", 32'(frame_start), 32'd1);
        check("t3_b2b_busy", 32'(busy), 32'd1);
        check("t3_drop", 32'(drop_cnt), 32'd1);
        wait_idle(FL + 10);

        // Flood of requests saturates the drop counter.
        pulse();
        rtc_tick = 1'b1;
        wait_cyc(400);
        rtc_tick = 1'b0;
        check("t4_drop_sat", 32'(drop_cnt), 32'd255);
        wait_idle(3 * FL);

        // Reset mid-frame with a pending request.
        pulse();
        pulse();
        wait_cyc(7 * C + 2);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_sl", 32'(sl), 32'd0);
        check("t5_sel", 32'(sel), 32'd0);
        check("t5_clr", 32'(cnt_clr), 32'd0);
        check("t5_drop", 32'(drop_cnt), 32'd0);
        saw = 1'b0;
        for (int i = 0; i < FL + 10; i++) begin
            @(negedge clk);
            if (busy || cnt_clr) saw = 1'b1;
        end
        check("t5_pending_lost", 32'(saw), 32'd0);

`ifdef FRAME_SEQ_PARITY_EN
        // Parity slot timing and values.
        word_in = 12'h0A3;
        pulse();
        word_in = 12'h001;
        wait_cyc(13);
        check("t6_pv", 32'(par_valid), 32'd1);
        check("t6_pb0", 32'(par_bit), 32'd0);
        @(negedge clk);
        check("t6_load1", 32'(sl), 32'd1);
        wait_cyc(13);
        check("t6_pb1", 32'(par_bit), 32'd1);
        word_in = '0;
        cycles_to_clr(400, n);
        check("t6_clear_offset", 32'(n + 27), 32'd224);
        wait_idle(10);
`endif

        // Random requests, overflow toggles and data.
        for (int i = 0; i < 4000; i++) begin
            rtc_tick = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 79) == 0) ovf = ~ovf;
            word_in = 12'($urandom);
            reset = (i == 2500) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        rtc_tick = 1'b0; ovf = 1'b0; reset = 1'b1;
        wait_idle(3 * FL);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
